// File: rtl/sqrt_ctrl_pkg.sv
// Shared types and helpers for the sqrt arbiter: FSM states, float32 constants
// and the special-case classifier that decides whether the sqrt unit is needed.
package sqrt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_t;

    localparam logic [31:0] F32_QNAN      = 32'h7fc00000;
    localparam logic [31:0] F32_PINF      = 32'h7f800000;
    localparam logic [31:0] F32_QUIET_BIT = 32'h00400000;

    typedef struct packed {
        logic        bypass;
        logic [31:0] result;
    } classify_t;

    // Operands with a closed-form square root never reach the shared unit.
    function automatic classify_t classify(input logic [31:0] a);
        classify_t  c;
        logic [7:0] e;
        logic [22:0] m;
        e        = a[30:23];
        m        = a[22:0];
        c.bypass = 1'b1;
        c.result = a;
        if (e == 8'hff && m != '0) begin
            c.result = a | F32_QUIET_BIT;
        end else if (a[30:0] == '0) begin
            c.result = a;
        end else if (a == F32_PINF) begin
            c.result = F32_PINF;
        end else if (a[31]) begin
            c.result = F32_QNAN;
        end else begin
            c.bypass = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/sqrt_f32_arbiter_if.sv
// Requester-side bundle of the sqrt arbiter: per-PE operand handshake plus the
// shared response bus.
interface sqrt_f32_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_a;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ-1:0]    rsp_ready;
    logic [31:0]         rsp_data;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N; returns a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);
    localparam logic [W:0] N_W = (W+1)'(N);

    logic [N-1:0] rot;
    logic [W-1:0] pos [N];

    // rot[k] is the request k places after the pointer; N need not be a power of two.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [W:0] sum;
            assign sum     = {1'b0, ptr} + (W+1)'(gi);
            assign pos[gi] = (sum >= N_W) ? W'(sum - N_W) : sum[W-1:0];
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    always_comb begin
        logic found;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found       = 1'b1;
                idx         = pos[k];
                gnt[pos[k]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_f32_arbiter.sv
// Shares one float32 sqrt unit between N_REQ requesters: round-robin accept,
// special-case bypass, and a reset/release/wait sequence around the unit.
module sqrt_f32_arbiter
    import sqrt_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    sqrt_f32_arbiter_if.slave pe,
    output logic              busy,
    output logic              sq_rst,
    output logic [31:0]       sq_a,
    input  logic              sq_rdy,
    input  logic [31:0]       sq_sqrt
);
    localparam int PW   = $clog2(N_REQ);
    localparam int CMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_PORT = PW'(N_REQ - 1);

    state_t        state_reg, state_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic [PW-1:0] owner_reg, owner_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   sq_a_reg, sq_a_next;
    logic [31:0]   rsp_data_reg, rsp_data_next;
    logic          rsp_err_reg, rsp_err_next;

    logic [N_REQ-1:0] gnt;
    logic [PW-1:0]    gnt_idx;
    logic [N_REQ-1:0] owner_oh;
    logic [31:0]      req_op [N_REQ];
    logic [31:0]      acc_op;
    classify_t        cls;
    logic             accept;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (pe.req_valid),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
            assign req_op[gi]   = pe.req_a[32*gi +: 32];
            assign owner_oh[gi] = (owner_reg == PW'(gi));
        end
    endgenerate

    assign acc_op = req_op[gnt_idx];
    assign cls    = classify(acc_op);
    assign accept = (state_reg == IDLE) && (gnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            cnt_reg      <= '0;
            sq_a_reg     <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            cnt_reg      <= cnt_next;
            sq_a_reg     <= sq_a_next;
            rsp_data_reg <= rsp_data_next;
            rsp_err_reg  <= rsp_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        cnt_next      = cnt_reg;
        sq_a_next     = sq_a_reg;
        rsp_data_next = rsp_data_reg;
        rsp_err_next  = rsp_err_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    owner_next = gnt_idx;
                    cnt_next   = '0;
                    if (cls.bypass) begin
                        rsp_data_next = cls.result;
                        rsp_err_next  = 1'b0;
                        state_next    = RESP;
                    end else begin
                        sq_a_next  = acc_op;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (cnt_reg == LOAD_LAST) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RUN: begin
                cnt_next = cnt_reg + CW'(1);
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (sq_rdy) begin
                    rsp_data_next = sq_sqrt;
                    rsp_err_next  = 1'b0;
                    state_next    = RESP;
                end else if (cnt_reg == RUN_LAST) begin
                    rsp_data_next = F32_QNAN;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end
            end
            RESP: begin
                if (pe.rsp_ready[owner_reg]) begin
                    ptr_next   = (owner_reg == LAST_PORT) ? '0 : owner_reg + PW'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pe.req_ready = (state_reg == IDLE) ? gnt : '0;
    assign pe.rsp_valid = (state_reg == RESP) ? owner_oh : '0;
    assign pe.rsp_data  = rsp_data_reg;
    assign pe.rsp_err   = rsp_err_reg;
    assign busy         = (state_reg != IDLE);
    assign sq_rst       = (state_reg != RUN);
    assign sq_a         = sq_a_reg;

endmodule

// File: tb/tb_sqrt_f32_arbiter.sv
// Self-checking bench for sqrt_f32_arbiter: a behavioural sqrt-unit model plus
// a float32 special-case / round-robin reference model.
module tb_sqrt_f32_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sqrt_f32_arbiter_if #(.N_REQ(N)) pe ();
    sqrt_f32_arbiter_if #(.N_REQ(N)) pe_to ();

    logic        busy, sq_rst, sq_rdy;
    logic [31:0] sq_a, sq_sqrt;
    logic        busy_to, sq_rst_to;
    logic [31:0] sq_a_to;
    wire         sq_rdy_to  = 1'b0;
    wire  [31:0] sq_sqrt_to = 32'h0;

    sqrt_f32_arbiter #(.N_REQ(N), .RST_CYCLES(2), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .pe(pe), .busy(busy), .sq_rst(sq_rst),
        .sq_a(sq_a), .sq_rdy(sq_rdy), .sq_sqrt(sq_sqrt)
    );

    sqrt_f32_arbiter #(.N_REQ(N), .RST_CYCLES(2), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .pe(pe_to), .busy(busy_to), .sq_rst(sq_rst_to),
        .sq_a(sq_a_to), .sq_rdy(sq_rdy_to), .sq_sqrt(sq_sqrt_to)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          model_ptr = 0;
    int          unit_lat = 20;
    bit          pend [N];
    logic [31:0] op [N];

    // Stand-in for the shared sqrt unit: exponent-halving approximation, exact for 2.0.
    function automatic logic [31:0] unit_result(input logic [31:0] a);
        if (a == 32'h40000000) return 32'h3fb504f3;
        return (a >> 1) + 32'h1fc00000;
    endfunction

    // Unit model: rdy rises after unit_lat released cycles (0 = never).
    int u_cnt;
    always @(posedge clk) begin
        if (sq_rst) begin
            u_cnt  <= 0;
            sq_rdy <= 1'b0;
        end else begin
            u_cnt <= u_cnt + 1;
            if (unit_lat > 0 && u_cnt + 1 >= unit_lat) begin
                sq_rdy  <= 1'b1;
                sq_sqrt <= unit_result(sq_a);
            end
        end
    end

    function automatic logic [31:0] ref_sqrt(input logic [31:0] a, output bit on_unit);
        bit          s;
        int          e;
        int unsigned m;
        s       = a[31];
        e       = int'(a[30:23]);
        m       = int'(a[22:0]);
        on_unit = 1'b0;
        if (e == 255 && m != 0) return a | 32'h00400000;
        if (e == 0 && m == 0)   return a;
        if (s)                  return 32'h7fc00000;
        if (e == 255)           return 32'h7f800000;
        on_unit = 1'b1;
        return unit_result(a);
    endfunction

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return {1'b0, 8'($urandom_range(1, 254)), r[22:0]};
            1: return {1'b1, r[30:0]} | 32'h00000001;
            2: return {r[31], 31'h0};
            3: return {r[31], 31'h7f800000};
            4: return {r[31], 8'hff, 23'($urandom_range(1, 23'h7fffff))};
            default: return {9'h0, 23'($urandom_range(1, 23'h7fffff))};
        endcase
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            pe.req_valid[i]        = pend[i];
            pe.req_a[32*i +: 32]   = op[i];
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Runs one full request/response transaction; entered and left on a negedge in IDLE.
    task automatic serve(output int who);
        int          w;
        int          waited;
        bit          on_unit;
        logic [31:0] exp_d;
        logic [N-1:0] exp_oh;
        who = -1;
        drive_reqs();
        #1;
        w = rr_pick();
        exp_oh    = '0;
        exp_oh[w] = 1'b1;
        exp_d     = ref_sqrt(op[w], on_unit);
        vectors++;
        if (pe.req_ready !== exp_oh) begin
            miscompares++;
            $display("FAIL grant: req_ready=%b expected %b (ptr %0d)", pe.req_ready, exp_oh, model_ptr);
        end
        @(posedge clk);
        @(negedge clk);
        pend[w]         = 1'b0;
        pe.req_valid[w] = 1'b0;
        waited = 0;
        while (pe.rsp_valid === '0 && waited < 3000) begin
            vectors++;
            if (pe.req_ready !== '0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_no_ready: req_ready=%b busy=%b expected 0/1", pe.req_ready, busy);
            end
            @(negedge clk);
            waited++;
        end
        if (waited >= 3000) begin
            miscompares++;
            $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected a response", waited);
            return;
        end
        if (!on_unit) begin
            vectors++;
            if (waited != 0 || sq_rst !== 1'b1) begin
                miscompares++;
                $display("FAIL bypass_latency: waited=%0d sq_rst=%b expected 0/1", waited, sq_rst);
            end
        end
        vectors++;
        if (pe.rsp_valid !== exp_oh) begin
            miscompares++;
            $display("FAIL rsp_owner: rsp_valid=%b expected %b", pe.rsp_valid, exp_oh);
        end
        vectors++;
        if (pe.rsp_data !== exp_d || pe.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp_data: a=%h got %h err=%b expected %h err=0", op[w], pe.rsp_data, pe.rsp_err, exp_d);
        end
        pe.rsp_ready = ~exp_oh;
        @(negedge clk);
        vectors++;
        if (pe.rsp_valid !== exp_oh) begin
            miscompares++;
            $display("FAIL foreign_ready: rsp_valid=%b expected %b", pe.rsp_valid, exp_oh);
        end
        pe.rsp_ready = exp_oh;
        @(negedge clk);
        pe.rsp_ready = '0;
        vectors++;
        if (busy !== 1'b0 || pe.rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL release: busy=%b rsp_valid=%b expected 0/0", busy, pe.rsp_valid);
        end
        model_ptr = (w + 1) % N;
        who = w;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (sq_rst !== 1'b1 || sq_a !== 32'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_unit: sq_rst=%b sq_a=%h busy=%b expected 1/0/0", sq_rst, sq_a, busy);
        end
        vectors++;
        if (pe.rsp_valid !== '0 || pe.rsp_data !== 32'h0 || pe.rsp_err !== 1'b0 || pe.req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_bus: rsp_valid=%b data=%h err=%b req_ready=%b expected zeros",
                     pe.rsp_valid, pe.rsp_data, pe.rsp_err, pe.req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (sq_rst_to !== 1'b1 || busy_to !== 1'b0 || pe_to.rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL reset_to: sq_rst=%b busy=%b rsp_valid=%b expected 1/0/0", sq_rst_to, busy_to, pe_to.rsp_valid);
        end
    endtask

    task automatic test_basic();
        int run;
        unit_lat = 20;
        pe.req_valid    = 4'b0001;
        pe.req_a[31:0]  = 32'h40000000;
        #1;
        vectors++;
        if (pe.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL basic_grant: req_ready=%b expected 0001", pe.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        pe.req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (sq_rst !== 1'b1 || sq_a !== 32'h40000000 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_load%0d: sq_rst=%b sq_a=%h busy=%b expected 1/40000000/1", c, sq_rst, sq_a, busy);
            end
            @(negedge clk);
        end
        vectors++;
        if (sq_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release: sq_rst=%b expected 0", sq_rst);
        end
        run = 0;
        while (pe.rsp_valid === '0 && run < 200) begin
            if (sq_rst === 1'b0) run++;
            @(negedge clk);
        end
        // rdy rises after 20 released cycles and is sampled one edge later.
        vectors++;
        if (run != 21) begin
            miscompares++;
            $display("FAIL basic_run_len: run cycles=%0d expected 21", run);
        end
        vectors++;
        if (pe.rsp_valid !== 4'b0001 || pe.rsp_data !== 32'h3fb504f3 || pe.rsp_err !== 1'b0 || sq_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_rsp: valid=%b data=%h err=%b sq_rst=%b expected 0001/3fb504f3/0/1",
                     pe.rsp_valid, pe.rsp_data, pe.rsp_err, sq_rst);
        end
        pe.rsp_ready = 4'b0001;
        @(negedge clk);
        pe.rsp_ready = '0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle: busy=%b expected 0", busy);
        end
        model_ptr = 1;
    endtask

    task automatic test_simultaneous();
        int got [8];
        int n;
        int who;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        unit_lat = 6;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            op[i]   = 32'h40000000 + 32'(i) * 32'h00400000;
        end
        n = 0;
        while (rr_pick() >= 0 && n < 8) begin
            serve(who);
            got[n] = who;
            n++;
            if (who == 2) begin
                pend[0] = 1'b1;
                op[0]   = 32'h40100000;
            end
        end
        drive_reqs();
        vectors++;
        if (n != 5 || got[0] != exp_order[0] || got[1] != exp_order[1] || got[2] != exp_order[2] ||
            got[3] != exp_order[3] || got[4] != exp_order[4]) begin
            miscompares++;
            $display("FAIL grant_order: got n=%0d %0d,%0d,%0d,%0d,%0d expected 0,1,2,3,0",
                     n, got[0], got[1], got[2], got[3], got[4]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] ins  [4] = '{32'hc0000000, 32'h80000000, 32'h7f800000, 32'h7f800001};
        logic [31:0] outs [4] = '{32'h7fc00000, 32'h80000000, 32'h7f800000, 32'h7fc00001};
        for (int t = 0; t < 4; t++) begin
            pe.req_valid       = 4'b0010;
            pe.req_a[63:32]    = ins[t];
            #1;
            @(posedge clk);
            @(negedge clk);
            pe.req_valid = '0;
            vectors++;
            if (pe.rsp_valid !== 4'b0010 || pe.rsp_data !== outs[t] || pe.rsp_err !== 1'b0 || sq_rst !== 1'b1) begin
                miscompares++;
                $display("FAIL bypass %h: valid=%b data=%h err=%b sq_rst=%b expected 0010/%h/0/1",
                         ins[t], pe.rsp_valid, pe.rsp_data, pe.rsp_err, sq_rst, outs[t]);
            end
            pe.rsp_ready = 4'b0010;
            @(negedge clk);
            pe.rsp_ready = '0;
            vectors++;
            if (sq_rst !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bypass_idle: sq_rst=%b busy=%b expected 1/0", sq_rst, busy);
            end
        end
        model_ptr = 2;
    endtask

    task automatic test_timeout();
        int w;
        int cnt;
        pe_to.req_valid      = 4'b0010;
        pe_to.req_a[63:32]   = 32'h40000000;
        #1;
        vectors++;
        if (pe_to.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL to_grant: req_ready=%b expected 0010", pe_to.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        pe_to.req_valid = '0;
        w = 0;
        while (sq_rst_to !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (w != 2) begin
            miscompares++;
            $display("FAIL to_load_len: load cycles=%0d expected 2", w);
        end
        cnt = 0;
        while (pe_to.rsp_valid === '0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        vectors++;
        if (cnt != 16) begin
            miscompares++;
            $display("FAIL to_latency: cycles from RUN entry=%0d expected 16", cnt);
        end
        vectors++;
        if (pe_to.rsp_valid !== 4'b0010 || pe_to.rsp_data !== 32'h7fc00000 || pe_to.rsp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_rsp: valid=%b data=%h err=%b expected 0010/7fc00000/1",
                     pe_to.rsp_valid, pe_to.rsp_data, pe_to.rsp_err);
        end
        pe_to.rsp_ready = 4'b0010;
        @(negedge clk);
        pe_to.rsp_ready = '0;
        vectors++;
        if (busy_to !== 1'b0) begin
            miscompares++;
            $display("FAIL to_idle: busy=%b expected 0", busy_to);
        end
    endtask

    task automatic test_backpressure();
        int w;
        int who;
        unit_lat = 8;
        pe.req_valid      = 4'b0100;
        pe.req_a[95:64]   = 32'h40800000;
        #1;
        @(posedge clk);
        @(negedge clk);
        pe.req_valid    = 4'b0001;
        pe.req_a[31:0]  = 32'h7f800000;
        w = 0;
        while (pe.rsp_valid === '0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (pe.rsp_valid !== 4'b0100 || pe.rsp_data !== unit_result(32'h40800000) || pe.req_ready !== '0) begin
                miscompares++;
                $display("FAIL backpressure%0d: valid=%b data=%h req_ready=%b expected 0100/%h/0000",
                         c, pe.rsp_valid, pe.rsp_data, pe.req_ready, unit_result(32'h40800000));
            end
            @(negedge clk);
        end
        pe.rsp_ready = 4'b0100;
        @(negedge clk);
        pe.rsp_ready = '0;
        model_ptr = 3;
        pend[0] = 1'b1;
        op[0]   = 32'h7f800000;
        serve(who);
    endtask

    task automatic test_reset_mid_run();
        int w;
        int who;
        unit_lat = 0;
        pe.req_valid       = 4'b1000;
        pe.req_a[127:96]   = 32'h40000000;
        #1;
        @(posedge clk);
        @(negedge clk);
        pe.req_valid = '0;
        w = 0;
        while (sq_rst !== 1'b0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (sq_rst !== 1'b1 || sq_a !== 32'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_unit: sq_rst=%b sq_a=%h busy=%b expected 1/0/0", sq_rst, sq_a, busy);
        end
        vectors++;
        if (pe.rsp_valid !== '0 || pe.rsp_data !== 32'h0 || pe.rsp_err !== 1'b0 || pe.req_ready !== '0) begin
            miscompares++;
            $display("FAIL midrst_bus: valid=%b data=%h err=%b req_ready=%b expected zeros",
                     pe.rsp_valid, pe.rsp_data, pe.rsp_err, pe.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (pe.rsp_valid !== '0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_dropped: valid=%b busy=%b expected 0/0", pe.rsp_valid, busy);
            end
            @(negedge clk);
        end
        unit_lat = 5;
        pend[0] = 1'b1; op[0] = 32'h41100000;
        pend[2] = 1'b1; op[2] = 32'h41800000;
        serve(who);
        vectors++;
        if (who != 0) begin
            miscompares++;
            $display("FAIL midrst_first: granted port %0d expected 0", who);
        end
        serve(who);
        drive_reqs();
    endtask

    task automatic test_random();
        int who;
        int n;
        int p;
        for (int it = 0; it < 25; it++) begin
            unit_lat = $urandom_range(1, 25);
            for (int i = 0; i < N; i++) begin
                pend[i] = ($urandom_range(0, 1) == 1);
                op[i]   = rand_op();
            end
            n = 0;
            while (rr_pick() >= 0 && n < 12) begin
                serve(who);
                n++;
                if ($urandom_range(0, 2) == 0) begin
                    p = $urandom_range(0, N - 1);
                    if (!pend[p]) begin
                        pend[p] = 1'b1;
                        op[p]   = rand_op();
                    end
                end
            end
            drive_reqs();
            @(negedge clk);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        pe.req_valid    = '0;
        pe.req_a        = '0;
        pe.rsp_ready    = '0;
        pe_to.req_valid = '0;
        pe_to.req_a     = '0;
        pe_to.rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            op[i]   = 32'h0;
        end
        test_reset();
        test_basic();
        test_simultaneous();
        @(negedge clk);
        test_bypass();
        test_timeout();
        test_backpressure();
        @(negedge clk);
        test_reset_mid_run();
        @(negedge clk);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
